operand_fetch_stage: RTL and testbench

//  ID->EX pipeline stage built around RegisterFile. Drives the RF read addresses from the decoded rs1/rs2 and

---
 rtl/operand_fetch_stage.sv | 129 ++++++++++++
 tb/tb_operand_fetch_stage.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/operand_fetch_stage.sv
// ID->EX operand fetch: RF addressing, MEM/WB bypass, load-use stall, registered EX handoff.
// Latency: 1 cycle ID->EX, 1 instr/cycle when unstalled.
// Backpressure: EX register holds while ex_valid & !ex_ready; id_ready drops on hold, hazard or flush.
module operand_fetch_stage #(
    parameter int XLEN  = 32,
    parameter int PAY_W = 64
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             flush,
    input  logic             id_valid,
    output logic             id_ready,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic [4:0]       id_rd,
    input  logic             id_reg_write,
    input  logic             id_is_load,
    input  logic [PAY_W-1:0] id_payload,
    output logic [4:0]       rf_read_reg1,
    output logic [4:0]       rf_read_reg2,
    input  logic [XLEN-1:0]  rf_read_data1,
    input  logic [XLEN-1:0]  rf_read_data2,
    input  logic [4:0]       mem_rd,
    input  logic             mem_reg_write,
    input  logic             mem_is_load,
    input  logic [XLEN-1:0]  mem_result,
    input  logic [4:0]       wb_rd,
    input  logic             wb_reg_write,
    input  logic [XLEN-1:0]  wb_data,
    output logic             ex_valid,
    input  logic             ex_ready,
    output logic [XLEN-1:0]  ex_rs1_data,
    output logic [XLEN-1:0]  ex_rs2_data,
    output logic [4:0]       ex_rd,
    output logic             ex_reg_write,
    output logic             ex_is_load,
    output logic [PAY_W-1:0] ex_payload
);
    typedef struct packed {
        logic [XLEN-1:0]  rs1_data;
        logic [XLEN-1:0]  rs2_data;
        logic [4:0]       rd;
        logic             reg_write;
        logic             is_load;
        logic [PAY_W-1:0] payload;
    } ex_reg_t;

    ex_reg_t         ex_q;
    ex_reg_t         ex_d;
    logic            ex_vld_q;
    logic            adv;
    logic            hazard;
    logic            ex_load_hit;
    logic            mem_load_hit;
    logic [XLEN-1:0] rs1_dat;
    logic [XLEN-1:0] rs2_dat;

    // MEM result beats the WB write; a load in MEM has no result yet and is handled as a stall instead.
    function automatic logic [XLEN-1:0] resolve(
        input logic [4:0]      src,
        input logic [XLEN-1:0] rf_dat,
        input logic [4:0]      m_rd,
        input logic            m_wr,
        input logic            m_ld,
        input logic [XLEN-1:0] m_res,
        input logic [4:0]      w_rd,
        input logic            w_wr,
        input logic [XLEN-1:0] w_dat
    );
        if (src == 5'd0)
            return '0;
        else if (m_wr && !m_ld && (m_rd == src))
            return m_res;
        else if (w_wr && (w_rd == src))
            return w_dat;
        else
            return rf_dat;
    endfunction

    assign rf_read_reg1 = id_rs1;
    assign rf_read_reg2 = id_rs2;

    assign rs1_dat = resolve(id_rs1, rf_read_data1, mem_rd, mem_reg_write, mem_is_load, mem_result,
                             wb_rd, wb_reg_write, wb_data);
    assign rs2_dat = resolve(id_rs2, rf_read_data2, mem_rd, mem_reg_write, mem_is_load, mem_result,
                             wb_rd, wb_reg_write, wb_data);

    // rs2 is always treated as read, so instructions without rs2 may stall needlessly.
    assign ex_load_hit  = ex_vld_q && ex_q.is_load && ex_q.reg_write && (ex_q.rd != 5'd0) &&
                          ((ex_q.rd == id_rs1) || (ex_q.rd == id_rs2));
    assign mem_load_hit = mem_is_load && mem_reg_write && (mem_rd != 5'd0) &&
                          ((mem_rd == id_rs1) || (mem_rd == id_rs2));
    assign hazard       = id_valid && (ex_load_hit || mem_load_hit);
    assign adv          = !ex_vld_q || ex_ready;
    assign id_ready     = adv && !hazard && !flush;

    always_comb begin
        ex_d           = '0;
        ex_d.rs1_data  = rs1_dat;
        ex_d.rs2_data  = rs2_dat;
        ex_d.rd        = id_rd;
        ex_d.reg_write = id_reg_write;
        ex_d.is_load   = id_is_load;
        ex_d.payload   = id_payload;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ex_vld_q <= 1'b0;
            ex_q     <= '0;
        end else if (flush) begin
            ex_vld_q <= 1'b0;
        end else if (adv && id_valid && !hazard) begin
            ex_vld_q <= 1'b1;
            ex_q     <= ex_d;
        end else if (adv) begin
            ex_vld_q <= 1'b0;
        end
    end

    assign ex_valid     = ex_vld_q;
    assign ex_rs1_data  = ex_q.rs1_data;
    assign ex_rs2_data  = ex_q.rs2_data;
    assign ex_rd        = ex_q.rd;
    assign ex_reg_write = ex_q.reg_write;
    assign ex_is_load   = ex_q.is_load;
    assign ex_payload   = ex_q.payload;

endmodule

// File: tb/tb_operand_fetch_stage.sv
// Directed bench for operand_fetch_stage: bypass, load-use, backpressure, flush and streaming.
// Stimulus pushes expected EX contents; a negedge monitor pops them on every EX handshake.
module tb_operand_fetch_stage;
    logic        clk = 1'b0;
    logic        reset_n;
    logic        flush;
    logic        id_valid;
    logic        id_ready;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic        id_reg_write, id_is_load;
    logic [63:0] id_payload;
    logic [4:0]  rf_read_reg1, rf_read_reg2;
    logic [31:0] rf_read_data1, rf_read_data2;
    logic [4:0]  mem_rd;
    logic        mem_reg_write, mem_is_load;
    logic [31:0] mem_result;
    logic [4:0]  wb_rd;
    logic        wb_reg_write;
    logic [31:0] wb_data;
    logic        ex_valid, ex_ready;
    logic [31:0] ex_rs1_data, ex_rs2_data;
    logic [4:0]  ex_rd;
    logic        ex_reg_write, ex_is_load;
    logic [63:0] ex_payload;

    logic [31:0] rf [32];

    typedef struct {
        logic [31:0] d1;
        logic [31:0] d2;
        logic [4:0]  rd;
        logic        rw;
        logic        ld;
        logic [63:0] pay;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   xfers    = 0;
    int   n_issued = 0;

    always #5 clk = ~clk;

    assign rf_read_data1 = rf[rf_read_reg1];
    assign rf_read_data2 = rf[rf_read_reg2];

    operand_fetch_stage #(.XLEN(32), .PAY_W(64)) dut (
        .clk(clk), .reset_n(reset_n), .flush(flush),
        .id_valid(id_valid), .id_ready(id_ready),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_reg_write(id_reg_write), .id_is_load(id_is_load), .id_payload(id_payload),
        .rf_read_reg1(rf_read_reg1), .rf_read_reg2(rf_read_reg2),
        .rf_read_data1(rf_read_data1), .rf_read_data2(rf_read_data2),
        .mem_rd(mem_rd), .mem_reg_write(mem_reg_write), .mem_is_load(mem_is_load),
        .mem_result(mem_result),
        .wb_rd(wb_rd), .wb_reg_write(wb_reg_write), .wb_data(wb_data),
        .ex_valid(ex_valid), .ex_ready(ex_ready),
        .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data), .ex_rd(ex_rd),
        .ex_reg_write(ex_reg_write), .ex_is_load(ex_is_load), .ex_payload(ex_payload)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_exp(input logic [31:0] d1, input logic [31:0] d2, input logic [4:0] rd,
                            input logic rw, input logic ld, input logic [63:0] pay);
        exp_t e;
        e.d1 = d1; e.d2 = d2; e.rd = rd; e.rw = rw; e.ld = ld; e.pay = pay;
        exp_q.push_back(e);
        n_issued++;
    endtask

    task automatic set_id(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                          input logic rw, input logic ld, input logic [63:0] pay);
        id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
        id_reg_write = rw; id_is_load = ld; id_payload = pay;
        id_valid = 1'b1;
    endtask

    // Presents one instruction and returns one posedge after it was accepted; id_valid stays high.
    task automatic issue(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                         input logic rw, input logic ld, input logic [63:0] pay,
                         input logic [31:0] e1, input logic [31:0] e2, output int waits);
        set_id(rs1, rs2, rd, rw, ld, pay);
        push_exp(e1, e2, rd, rw, ld, pay);
        waits = 0;
        @(negedge clk);
        while (!id_ready && waits < 20) begin
            @(negedge clk);
            waits++;
        end
        if (!id_ready) chk("issue_timeout", 64'(id_ready), 64'(1));
        @(posedge clk); #1;
    endtask

    always @(negedge clk) begin
        if (reset_n && ex_valid && ex_ready) begin
            exp_t e;
            xfers++;
            if (exp_q.size() == 0) begin
                chk("unexpected_xfer", ex_payload, 64'hFFFF_FFFF_FFFF_FFFF ^ ex_payload);
            end else begin
                e = exp_q.pop_front();
                chk("ex_rs1_data", 64'(ex_rs1_data), 64'(e.d1));
                chk("ex_rs2_data", 64'(ex_rs2_data), 64'(e.d2));
                chk("ex_rd", 64'(ex_rd), 64'(e.rd));
                chk("ex_reg_write", 64'(ex_reg_write), 64'(e.rw));
                chk("ex_is_load", 64'(ex_is_load), 64'(e.ld));
                chk("ex_payload", ex_payload, e.pay);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        int stall_sum;
        int x0;
        for (int i = 0; i < 32; i++) rf[i] = 32'h100 + 32'(i);
        rf[0] = 32'hDEAD; rf[3] = 32'h33; rf[5] = 32'hA; rf[7] = 32'h7777;

        reset_n = 1'b0; flush = 1'b0; ex_ready = 1'b1;
        mem_rd = 5'd0; mem_reg_write = 1'b0; mem_is_load = 1'b0; mem_result = 32'h0;
        wb_rd = 5'd0; wb_reg_write = 1'b0; wb_data = 32'h0;
        set_id(5'd5, 5'd0, 5'd1, 1'b1, 1'b0, 64'h1111);

        // 1: reset holds EX empty even with a valid ID instruction
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ex_valid", 64'(ex_valid), 64'(0));
        chk("rst_ex_rs1", 64'(ex_rs1_data), 64'(0));
        chk("rst_ex_rd", 64'(ex_rd), 64'(0));
        chk("rst_ex_payload", ex_payload, 64'h0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        push_exp(32'hA, 32'h0, 5'd1, 1'b1, 1'b0, 64'h1111);
        @(negedge clk);
        chk("t1_id_ready", 64'(id_ready), 64'(1));
        @(posedge clk); #1;
        id_valid = 1'b0;
        @(negedge clk);
        chk("t1_ex_valid", 64'(ex_valid), 64'(1));
        @(posedge clk); #1;

        // 2: bypass priority MEM > WB > RF, x0 never forwarded
        mem_rd = 5'd3; mem_reg_write = 1'b1; mem_result = 32'h11;
        wb_rd = 5'd3; wb_reg_write = 1'b1; wb_data = 32'h22;
        issue(5'd3, 5'd3, 5'd2, 1'b1, 1'b0, 64'h2001, 32'h11, 32'h11, w);
        mem_reg_write = 1'b0;
        issue(5'd3, 5'd3, 5'd2, 1'b1, 1'b0, 64'h2002, 32'h22, 32'h22, w);
        wb_reg_write = 1'b0;
        issue(5'd3, 5'd3, 5'd2, 1'b1, 1'b0, 64'h2003, 32'h33, 32'h33, w);
        mem_rd = 5'd0; mem_reg_write = 1'b1; wb_rd = 5'd0; wb_reg_write = 1'b1;
        issue(5'd0, 5'd0, 5'd2, 1'b1, 1'b0, 64'h2004, 32'h0, 32'h0, w);
        mem_reg_write = 1'b0; wb_reg_write = 1'b0; wb_rd = 5'd0;

        // 3: load to x7 followed by a reader of x7 costs two bubbles
        issue(5'd1, 5'd2, 5'd7, 1'b1, 1'b1, 64'h3001, rf[1], rf[2], w);
        set_id(5'd7, 5'd0, 5'd8, 1'b1, 1'b0, 64'h3002);
        push_exp(32'h77, 32'h0, 5'd8, 1'b1, 1'b0, 64'h3002);
        @(negedge clk);
        chk("t3_stall1_id_ready", 64'(id_ready), 64'(0));
        @(posedge clk); #1;
        mem_rd = 5'd7; mem_reg_write = 1'b1; mem_is_load = 1'b1; mem_result = 32'hBAD;
        @(negedge clk);
        chk("t3_stall2_id_ready", 64'(id_ready), 64'(0));
        chk("t3_bubble1", 64'(ex_valid), 64'(0));
        @(posedge clk); #1;
        mem_reg_write = 1'b0; mem_is_load = 1'b0; mem_rd = 5'd0;
        wb_rd = 5'd7; wb_reg_write = 1'b1; wb_data = 32'h77;
        @(negedge clk);
        chk("t3_release_id_ready", 64'(id_ready), 64'(1));
        chk("t3_bubble2", 64'(ex_valid), 64'(0));
        @(posedge clk); #1;
        id_valid = 1'b0; wb_reg_write = 1'b0;
        @(negedge clk);
        chk("t3_issue_ex_valid", 64'(ex_valid), 64'(1));
        @(posedge clk); #1;

        // 4: EX backpressure freezes the register, operands included
        issue(5'd4, 5'd0, 5'd10, 1'b1, 1'b0, 64'h4001, rf[4], 32'h0, w);
        ex_ready = 1'b0;
        set_id(5'd6, 5'd0, 5'd9, 1'b1, 1'b0, 64'h4002);
        push_exp(rf[6], 32'h0, 5'd9, 1'b1, 1'b0, 64'h4002);
        wb_rd = 5'd4; wb_reg_write = 1'b1; wb_data = 32'h99;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("t4_hold_valid", 64'(ex_valid), 64'(1));
            chk("t4_hold_id_ready", 64'(id_ready), 64'(0));
            chk("t4_hold_rs1", 64'(ex_rs1_data), 64'(rf[4]));
            chk("t4_hold_payload", ex_payload, 64'h4001);
            @(posedge clk); #1;
        end
        ex_ready = 1'b1;
        @(negedge clk);
        chk("t4_resume_id_ready", 64'(id_ready), 64'(1));
        @(posedge clk); #1;
        id_valid = 1'b0; wb_reg_write = 1'b0;
        @(negedge clk);
        chk("t4_next_loaded", 64'(ex_valid), 64'(1));
        @(posedge clk); #1;

        // 5: flush with a valid ID instruction and a consumed EX instruction
        issue(5'd11, 5'd12, 5'd13, 1'b1, 1'b0, 64'h5001, rf[11], rf[12], w);
        flush = 1'b1;
        set_id(5'd14, 5'd15, 5'd16, 1'b1, 1'b0, 64'h5002);
        @(negedge clk);
        chk("t5_flush_id_ready", 64'(id_ready), 64'(0));
        @(posedge clk); #1;
        flush = 1'b0; id_valid = 1'b0;
        @(negedge clk);
        chk("t5_flush_ex_valid", 64'(ex_valid), 64'(0));
        repeat (2) @(posedge clk);
        #1;

        // 6: eight independent instructions back to back
        stall_sum = 0;
        x0 = xfers;
        for (int i = 0; i < 8; i++) begin
            issue(5'(i + 8), 5'(i + 16), 5'(i + 1), 1'b1, 1'b0, 64'hA000 + 64'(i),
                  rf[i + 8], rf[i + 16], w);
            stall_sum += w;
        end
        id_valid = 1'b0;
        @(posedge clk); #1;
        chk("t6_no_stalls", 64'(stall_sum), 64'(0));
        chk("t6_xfers", 64'(xfers - x0), 64'(8));

        repeat (3) @(posedge clk);
        #1;
        chk("queue_empty", 64'(exp_q.size()), 64'(0));
        chk("xfer_total", 64'(xfers), 64'(n_issued));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
